// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared Fibonacci LFSR step function, default seed and checker state encoding
package lfsr_pkg;

  localparam int LFSR_MAX_W = 32;

  localparam logic [LFSR_MAX_W-1:0] LFSR_DEFAULT_SEED = '1;

  localparam logic ST_SEED   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  typedef enum logic {
    S_SEED   = ST_SEED,
    S_LOCKED = ST_LOCKED
  } chk_state_e;

  // One generator advance: 'bits' single-bit shifts, new MSB = x[bits-1] ^ x[1].
  // Operates on the low 'bits' of a zero-extended word so any width up to LFSR_MAX_W shares it.
  function automatic logic [LFSR_MAX_W-1:0] lfsr_step(input logic [LFSR_MAX_W-1:0] x,
                                                       input int bits);
    logic [LFSR_MAX_W-1:0] r;
    logic [LFSR_MAX_W-1:0] top_m;
    logic fb;
    r = x;
    top_m = LFSR_MAX_W'(1) << (bits - 1);
    for (int i = 0; i < LFSR_MAX_W; i++) begin
      if (i < bits) begin
        fb = (|(r & top_m)) ^ (|(r & LFSR_MAX_W'(2)));
        r = (r >> 1) | (fb ? top_m : '0);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/lfsr_stream_checker_if.sv
// rtl/lfsr_stream_checker_if.sv - received LFSR word stream handshake
interface lfsr_stream_checker_if #(
  parameter int BITS = 5
) ();
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/lfsr_step_comb.sv
// rtl/lfsr_step_comb.sv - combinational single generator advance of a BITS-wide LFSR word
module lfsr_step_comb
  import lfsr_pkg::*;
#(
  parameter int BITS = 5
) (
  input  logic [BITS-1:0] i_x,
  output logic [BITS-1:0] o_y
);

  assign o_y = BITS'(lfsr_step(LFSR_MAX_W'(i_x), BITS));

endmodule

// File: rtl/lfsr_stream_checker.sv
// rtl/lfsr_stream_checker.sv - self-seeding LFSR stream checker with saturating error count
// Optional first-error capture ports under LFSR_STREAM_CHECKER_CAPTURE_EN.
module lfsr_stream_checker
  import lfsr_pkg::*;
#(
  parameter int BITS        = 5,
  parameter int CNT_W       = 16,
  parameter int LOSS_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  lfsr_stream_checker_if.slave s_in,
  input  logic                 clr_cnt,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [CNT_W-1:0]     err_count
`ifdef LFSR_STREAM_CHECKER_CAPTURE_EN
  ,
  output logic [BITS-1:0]      first_err_exp,
  output logic [BITS-1:0]      first_err_got,
  output logic                 cap_valid
`endif
);

  localparam logic [7:0] LOSS_T8 = 8'(LOSS_THRESH);

  chk_state_e       r_state;
  logic [BITS-1:0]  r_expected;
  logic [7:0]       r_miss_run;
  logic [CNT_W-1:0] r_err_count;
  logic             r_err_pulse;
  logic             r_in_ready;

  logic [BITS-1:0]  w_step_in;
  logic [BITS-1:0]  w_step_exp;
  logic             w_accept;
  logic             w_match;
  logic [7:0]       w_miss_inc;

`ifdef LFSR_STREAM_CHECKER_CAPTURE_EN
  logic [BITS-1:0]  r_cap_exp;
  logic [BITS-1:0]  r_cap_got;
  logic             r_cap_valid;
`endif

  lfsr_step_comb #(.BITS(BITS)) u_step_in (
    .i_x (s_in.in_data),
    .o_y (w_step_in)
  );

  lfsr_step_comb #(.BITS(BITS)) u_step_exp (
    .i_x (r_expected),
    .o_y (w_step_exp)
  );

  assign w_accept   = s_in.in_valid & r_in_ready;
  assign w_match    = (s_in.in_data == r_expected);
  assign w_miss_inc = r_miss_run + 8'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_SEED;
      r_expected  <= '0;
      r_miss_run  <= '0;
      r_err_count <= '0;
      r_err_pulse <= 1'b0;
      r_in_ready  <= 1'b0;
`ifdef LFSR_STREAM_CHECKER_CAPTURE_EN
      r_cap_exp   <= '0;
      r_cap_got   <= '0;
      r_cap_valid <= 1'b0;
`endif
    end else begin
      r_in_ready  <= 1'b1;
      r_err_pulse <= 1'b0;
      if (w_accept) begin
        if (r_state == S_SEED) begin
          // All-zero is the LFSR lockup word and can never seed a live sequence.
          if (s_in.in_data != '0) begin
            r_expected <= w_step_in;
            r_state    <= S_LOCKED;
          end
        end else if (w_match) begin
          r_expected <= w_step_in;
          r_miss_run <= '0;
        end else begin
          r_err_pulse <= 1'b1;
          if (~&r_err_count) r_err_count <= r_err_count + 1'b1;
          // Free-run the prediction so one corrupted word cannot poison it.
          r_expected <= w_step_exp;
          if (w_miss_inc == LOSS_T8) begin
            r_state    <= S_SEED;
            r_miss_run <= '0;
          end else begin
            r_miss_run <= w_miss_inc;
          end
`ifdef LFSR_STREAM_CHECKER_CAPTURE_EN
          if (!r_cap_valid) begin
            r_cap_exp   <= r_expected;
            r_cap_got   <= s_in.in_data;
            r_cap_valid <= 1'b1;
          end
`endif
        end
      end
      if (clr_cnt) begin
        r_err_count <= '0;
        r_miss_run  <= '0;
`ifdef LFSR_STREAM_CHECKER_CAPTURE_EN
        r_cap_exp   <= '0;
        r_cap_got   <= '0;
        r_cap_valid <= 1'b0;
`endif
      end
    end
  end

  assign s_in.in_ready = r_in_ready;
  assign locked        = (r_state == S_LOCKED);
  assign err_pulse     = r_err_pulse;
  assign err_count     = r_err_count;

`ifdef LFSR_STREAM_CHECKER_CAPTURE_EN
  assign first_err_exp = r_cap_exp;
  assign first_err_got = r_cap_got;
  assign cap_valid     = r_cap_valid;
`endif

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// tb/tb_lfsr_stream_checker.sv - table-driven bench for lfsr_stream_checker (default and saturating builds)
module tb_lfsr_stream_checker;

  typedef struct {
    logic        valid;
    logic [4:0]  data;
    logic        clr;
    logic        locked;
    logic        pulse;
    logic [15:0] cnt;
    logic        cap_v;
    logic [4:0]  cap_e;
    logic [4:0]  cap_g;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic clr_a, clr_b;
  logic locked_a, locked_b, pulse_a, pulse_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;
  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lfsr_stream_checker_if #(.BITS(5)) s_a ();
  lfsr_stream_checker_if #(.BITS(5)) s_b ();

`ifdef LFSR_STREAM_CHECKER_CAPTURE_EN
  logic [4:0] cexp_a, cgot_a, cexp_b, cgot_b;
  logic       cv_a, cv_b;
`endif

  lfsr_stream_checker #(.BITS(5), .CNT_W(16), .LOSS_THRESH(4)) dut (
    .clk (clk), .rst (rst), .s_in (s_a.slave), .clr_cnt (clr_a),
    .locked (locked_a), .err_pulse (pulse_a), .err_count (cnt_a)
`ifdef LFSR_STREAM_CHECKER_CAPTURE_EN
    , .first_err_exp (cexp_a), .first_err_got (cgot_a), .cap_valid (cv_a)
`endif
  );

  lfsr_stream_checker #(.BITS(5), .CNT_W(2), .LOSS_THRESH(8)) dut_sat (
    .clk (clk), .rst (rst), .s_in (s_b.slave), .clr_cnt (clr_b),
    .locked (locked_b), .err_pulse (pulse_b), .err_count (cnt_b)
`ifdef LFSR_STREAM_CHECKER_CAPTURE_EN
    , .first_err_exp (cexp_b), .first_err_got (cgot_b), .cap_valid (cv_b)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic v, input logic [4:0] d, input logic c,
                              input logic lk, input logic p, input logic [15:0] n,
                              input logic cv, input logic [4:0] ce, input logic [4:0] cg);
    vec_t r;
    r.valid = v; r.data = d; r.clr = c; r.locked = lk; r.pulse = p; r.cnt = n;
    r.cap_v = cv; r.cap_e = ce; r.cap_g = cg;
    return r;
  endfunction

  task automatic run_vec(input int which, input int idx, input vec_t v);
    string tag;
    if (which == 0) begin
      s_a.in_valid = v.valid; s_a.in_data = v.data; clr_a = v.clr;
    end else begin
      s_b.in_valid = v.valid; s_b.in_data = v.data; clr_b = v.clr;
    end
    @(posedge clk);
    #1;
    s_a.in_valid = 1'b0; clr_a = 1'b0;
    s_b.in_valid = 1'b0; clr_b = 1'b0;
    tag = $sformatf("%s[%0d]", (which == 0) ? "main" : "sat", idx);
    if (which == 0) begin
      chk({tag, ".locked"}, 32'(locked_a), 32'(v.locked));
      chk({tag, ".err_pulse"}, 32'(pulse_a), 32'(v.pulse));
      chk({tag, ".err_count"}, 32'(cnt_a), 32'(v.cnt));
`ifdef LFSR_STREAM_CHECKER_CAPTURE_EN
      chk({tag, ".cap_valid"}, 32'(cv_a), 32'(v.cap_v));
      chk({tag, ".first_err_exp"}, 32'(cexp_a), 32'(v.cap_e));
      chk({tag, ".first_err_got"}, 32'(cgot_a), 32'(v.cap_g));
`endif
    end else begin
      chk({tag, ".locked"}, 32'(locked_b), 32'(v.locked));
      chk({tag, ".err_pulse"}, 32'(pulse_b), 32'(v.pulse));
      chk({tag, ".err_count"}, 32'(cnt_b), 32'(v.cnt));
`ifdef LFSR_STREAM_CHECKER_CAPTURE_EN
      chk({tag, ".cap_valid"}, 32'(cv_b), 32'(v.cap_v));
      chk({tag, ".first_err_exp"}, 32'(cexp_b), 32'(v.cap_e));
      chk({tag, ".first_err_got"}, 32'(cgot_b), 32'(v.cap_g));
`endif
    end
  endtask

  vec_t main_tbl[17];
  vec_t sat_tbl[8];

  initial begin
    // Generator sequence for BITS=5 from 1f: 1f -> 1a -> 04 -> 1e -> 1a -> 04 -> 1e ...
    main_tbl[0]  = mk(1, 5'h00, 0, 0, 0, 0, 0, 5'h00, 5'h00);
    main_tbl[1]  = mk(1, 5'h1f, 0, 1, 0, 0, 0, 5'h00, 5'h00);
    main_tbl[2]  = mk(1, 5'h1a, 0, 1, 0, 0, 0, 5'h00, 5'h00);
    main_tbl[3]  = mk(1, 5'h04, 0, 1, 0, 0, 0, 5'h00, 5'h00);
    main_tbl[4]  = mk(1, 5'h1e, 0, 1, 0, 0, 0, 5'h00, 5'h00);
    main_tbl[5]  = mk(1, 5'h1a, 0, 1, 0, 0, 0, 5'h00, 5'h00);
    main_tbl[6]  = mk(1, 5'h05, 0, 1, 1, 1, 1, 5'h04, 5'h05);
    main_tbl[7]  = mk(1, 5'h1e, 0, 1, 0, 1, 1, 5'h04, 5'h05);
    main_tbl[8]  = mk(0, 5'h00, 1, 1, 0, 0, 0, 5'h00, 5'h00);
    main_tbl[9]  = mk(1, 5'h00, 0, 1, 1, 1, 1, 5'h1a, 5'h00);
    main_tbl[10] = mk(1, 5'h00, 0, 1, 1, 2, 1, 5'h1a, 5'h00);
    main_tbl[11] = mk(1, 5'h00, 0, 1, 1, 3, 1, 5'h1a, 5'h00);
    main_tbl[12] = mk(1, 5'h00, 0, 0, 1, 4, 1, 5'h1a, 5'h00);
    main_tbl[13] = mk(1, 5'h00, 0, 0, 0, 4, 1, 5'h1a, 5'h00);
    main_tbl[14] = mk(0, 5'h00, 0, 0, 0, 4, 1, 5'h1a, 5'h00);
    main_tbl[15] = mk(1, 5'h1a, 0, 1, 0, 4, 1, 5'h1a, 5'h00);
    main_tbl[16] = mk(1, 5'h04, 0, 1, 0, 4, 1, 5'h1a, 5'h00);

    // CNT_W=2, LOSS_THRESH=8: count sticks at 3, clear beats a coincident mismatch.
    sat_tbl[0] = mk(1, 5'h1f, 0, 1, 0, 0, 0, 5'h00, 5'h00);
    sat_tbl[1] = mk(1, 5'h00, 0, 1, 1, 1, 1, 5'h1a, 5'h00);
    sat_tbl[2] = mk(1, 5'h00, 0, 1, 1, 2, 1, 5'h1a, 5'h00);
    sat_tbl[3] = mk(1, 5'h00, 0, 1, 1, 3, 1, 5'h1a, 5'h00);
    sat_tbl[4] = mk(1, 5'h00, 0, 1, 1, 3, 1, 5'h1a, 5'h00);
    sat_tbl[5] = mk(1, 5'h00, 0, 1, 1, 3, 1, 5'h1a, 5'h00);
    sat_tbl[6] = mk(1, 5'h00, 1, 1, 1, 0, 0, 5'h00, 5'h00);
    sat_tbl[7] = mk(1, 5'h1a, 0, 1, 0, 0, 0, 5'h00, 5'h00);

    rst = 1'b1;
    clr_a = 1'b0; clr_b = 1'b0;
    s_a.in_valid = 1'b0; s_a.in_data = '0;
    s_b.in_valid = 1'b0; s_b.in_data = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.in_ready", 32'(s_a.in_ready), 32'd0);
    chk("reset.locked", 32'(locked_a), 32'd0);
    chk("reset.err_pulse", 32'(pulse_a), 32'd0);
    chk("reset.err_count", 32'(cnt_a), 32'd0);
    chk("reset.sat_err_count", 32'(cnt_b), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("release.in_ready", 32'(s_a.in_ready), 32'd1);
    chk("release.sat_in_ready", 32'(s_b.in_ready), 32'd1);

    for (int i = 0; i < 17; i++) run_vec(0, i, main_tbl[i]);
    for (int i = 0; i < 8; i++) run_vec(1, i, sat_tbl[i]);

    // Reset while locked with a nonzero count; first word offered during in_ready=0 is dropped.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst.locked", 32'(locked_a), 32'd0);
    chk("midrst.in_ready", 32'(s_a.in_ready), 32'd0);
    chk("midrst.err_count", 32'(cnt_a), 32'd0);
    s_a.in_valid = 1'b1; s_a.in_data = 5'h1e;
    @(posedge clk);
    #1;
    s_a.in_valid = 1'b0;
    chk("midrst.in_ready_back", 32'(s_a.in_ready), 32'd1);
    chk("midrst.not_accepted", 32'(locked_a), 32'd0);
    run_vec(0, 100, mk(1, 5'h1e, 0, 1, 0, 0, 0, 5'h00, 5'h00));
    run_vec(0, 101, mk(1, 5'h1a, 0, 1, 0, 0, 0, 5'h00, 5'h00));
    run_vec(0, 102, mk(1, 5'h04, 0, 1, 0, 0, 0, 5'h00, 5'h00));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/lfsr_stream_checker.md
Name: lfsr_stream_checker

Overview:
- Receive-side counterpart of the team's Fibonacci LFSR generator.
- Consumes the word stream the generator emits (one generator advance = BITS single-bit shifts), self-seeds from the stream, predicts each next word, and counts mismatches.
- Used as a BIST/monitor on the random-replacement path of the cache, and in benches to prove the generator sequence is intact.

Parameters:
- BITS, 5, LFSR/word width; feedback taps are bit BITS-1 and bit 1.
- CNT_W, 16, width of the error counter.
- LOSS_THRESH, 4, consecutive mismatches that drop lock; range 1..255.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset: rst, synchronous, active-high.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  checker can accept a word.
- in_data  input  BITS  received LFSR word.
- clr_cnt  input  1  synchronous clear of err_count and miss_run.
- locked  output  1  checker is tracking the sequence.
- err_pulse  output  1  one-cycle pulse: the last accepted word mismatched.
- err_count  output  CNT_W  saturating count of mismatches while locked.

Behaviour:
- step(x): repeat BITS times: x = {x[BITS-1]^x[1], x[BITS-1:1]}. Combinational, BITS iterations. Must match the generator bit-exactly.
- Accept: a word is accepted on a clk edge with in_valid & in_ready.
- in_ready: registered. 0 during and in the cycle of reset; 1 from the first cycle after rst deasserts. Never otherwise deasserted (no backpressure).
- Reset values: state=SEED, locked=0, err_pulse=0, err_count=0, expected=0, miss_run=0.
- FSM SEED:
  - Accept with in_data != 0: expected <= step(in_data), go LOCKED. locked=1 from the next cycle.
  - Accept with in_data == 0 (lockup word): ignored, stay in SEED, no count.
- FSM LOCKED, accepted word:
  - Match (in_data == expected): expected <= step(in_data), miss_run <= 0.
  - Mismatch: err_pulse=1 in the next cycle. err_count +1, saturating at all-ones. expected <= step(expected) (free-run prediction; a single corrupted word does not corrupt the prediction). miss_run +1.
  - If miss_run+1 == LOSS_THRESH: go SEED, locked=0 next cycle, miss_run <= 0. err_count is retained.
- No accept: all state holds; err_pulse=0.
- clr_cnt: clears err_count and miss_run next cycle. Applied together with a mismatch, the clear wins (count 0) and err_pulse still fires.
- rst mid-stream: returns to SEED and drops the in-flight prediction; the next valid word reseeds.
- Latency: 1 cycle from accept to err_pulse/locked/err_count update.

Optional Feature:
- Macro LFSR_STREAM_CHECKER_CAPTURE_EN.
- Defined: adds outputs first_err_exp[BITS] and first_err_got[BITS], plus a cap_valid flag.
  - On the first mismatch after reset or clr_cnt, they latch expected and in_data; cap_valid=1.
  - Later mismatches do not overwrite them.
  - rst or clr_cnt clears all three to 0.
- Undefined: these ports and registers do not exist. Behaviour is otherwise identical.

Decomposition:
- Shared package lfsr_pkg holds:
  - the step function, parameterised on BITS, so generator and checker share one definition;
  - the default seed constant (all ones);
  - state encoding localparams ST_SEED=0, ST_LOCKED=1.
- One natural sub-module: lfsr_step_comb (pure combinational step(x)), instanced twice, on in_data and on expected.

Test Plan:
- Reset, then in_valid for words 1f,1a,04,1e (BITS=5) -> locked=1 one cycle after 1f accepted; err_pulse never asserts; err_count=0.
- Lock with 1f,1a, then send 05 (expected 04), then 1e -> one err_pulse after 05; err_count=1; 1e matches (free-run), miss_run back to 0.
- Lock, then 4 consecutive wrong words (LOSS_THRESH=4) -> locked=0 after the 4th; err_count=4; next word 1a reseeds; locked=1 one cycle later.
- In SEED, feed 00 then 1f -> 00 ignored (locked stays 0); lock occurs on 1f.
- Saturation: CNT_W=2, force 5 mismatches with LOSS_THRESH=8 -> err_count sticks at 3. clr_cnt coincident with a mismatch -> err_count=0 and err_pulse=1.
- rst asserted mid-stream while locked -> next cycle locked=0, in_ready=0, err_count=0; after release, in_ready=1 and the stream relocks.
  - With LFSR_STREAM_CHECKER_CAPTURE_EN: a mismatch on 05 vs 04 latches first_err_exp=04, first_err_got=05; a later error leaves them unchanged.
